mac_sequencer: RTL and testbench
================================

Name: mac_sequencer

Overview:
Sequential controller that drives one binary multiplier stage (per-lane 1-bit weight AND 1-bit input, 2-bit product per lane) and accumulates the result into a neuron membrane.
- Holds the weight vector and latches each input vector.
- Serially sums the per-lane products, one lane per cycle.
- Applies a saturating accumulate, threshold-and-fire and shift-based leak, then emits one result per accepted input.
- Sits between the input-spike source and the output-spike sink, with the multiplier stage as its datapath.

Parameters:
N_STAGE, 5, log2 of lane count; N = 2**N_STAGE lanes.
ACC_W, 12, membrane / threshold width in bits.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
cfg_we  input  1  weight write strobe
cfg_wdata  input  N  weight vector to load
in_valid  input  1  input vector valid
in_ready  output  1  block can accept input (high only in IDLE)
in_x  input  N  input spike vector
w_out  output  N  to multiplier stage w, driven from weight register
x_out  output  N  to multiplier stage x, driven from latched input register
mult_in  input  2N  product vector from multiplier stage, lane i at bits [2i+1:2i]
threshold  input  ACC_W  firing threshold, sampled in UPDATE
leak_shift  input  3  leak amount; 0 = no leak
mem_clr  input  1  clear membrane
out_valid  output  1  one-cycle result strobe
spike  output  1  fire flag, valid with out_valid
membrane  output  ACC_W  current membrane register

Behaviour:
- Reset (rst_n low, async): state IDLE; weight reg, x reg, lane counter, psum, membrane, out_valid and spike all 0; in_ready = 1.
- Reset mid-operation aborts the operation: no out_valid is produced.
- in_ready is combinational: 1 iff state == IDLE.
- w_out and x_out are continuous register outputs; mult_in is treated as combinational from them.
- Weight load:
  - cfg_we writes cfg_wdata into the weight register only in IDLE.
  - cfg_we in SUM or UPDATE is ignored.
  - cfg_we and an in_valid handshake in the same IDLE cycle: both take effect; the new weights are used for that input.
- IDLE:
  - in_valid && in_ready: x reg <= in_x, cnt <= 0, psum <= 0, go to SUM.
  - Otherwise stay in IDLE.
- SUM:
  - Each cycle: psum <= psum + mult_in[2*cnt+1 : 2*cnt] (zero-extended), cnt <= cnt + 1.
  - When cnt == N-1, the last lane is added that cycle and the next state is UPDATE.
  - psum width is N_STAGE+2 bits, so it never overflows.
- UPDATE (one cycle):
  - m = membrane + psum, saturating at 2**ACC_W - 1.
  - If m >= threshold: spike <= 1, membrane <= 0.
  - Else: spike <= 0, membrane <= m - (m >> leak_shift), with leak applied only when leak_shift != 0.
  - out_valid <= 1 for exactly one cycle; next state IDLE.
- threshold == 0: every update fires.
- spike holds its value until the next UPDATE; out_valid is registered and 0 otherwise.
- Timing:
  - Handshake accepted at edge T; out_valid is high in the cycle after edge T+N+1.
  - Minimum spacing between accepted inputs is N+2 cycles.
- mem_clr: membrane <= 0 in any state and has priority over the UPDATE result. If it coincides with UPDATE, out_valid still pulses, with spike = 0 and membrane = 0.

Test Plan:
1. Reset: assert rst_n low mid-SUM -> out_valid, spike, membrane = 0, in_ready = 1 immediately; no later out_valid; after release, state IDLE.
2. Accumulate and fire (N=32, ACC_W=12): weights 0xFFFFFFFF, in_x 0x0000000F, threshold 10, leak_shift 0, three inputs -> membrane 4, 8, then spike = 1 with membrane 0 on the third out_valid; each out_valid occurs 33 cycles after its handshake.
3. Leak: weights and in_x all ones, threshold 4095, leak_shift 1 -> membrane 16, then 24, then 28; spike = 0.
4. Saturation: weights and in_x all ones, leak_shift 0, threshold 4095, 128 inputs -> membrane 4064 after 127; 128th saturates to 4095, spike = 1, membrane 0.
5. Protocol: in_valid held high during SUM -> in_ready = 0 and no second latch. cfg_we 0x0 during SUM -> ignored, result unchanged. cfg_we 0x000000FF with a handshake in the same IDLE cycle, in_x all ones -> psum 8.
6. mem_clr asserted in the UPDATE cycle with membrane 20 -> out_valid = 1, spike = 0, membrane = 0.

Source files
------------

// File: rtl/mac_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_sequencer_if
// Description : Bus bundle between the MAC sequencer, its spike source/sink
//               and the external binary multiplier stage.
// Revision    : 1.0  initial release
// ============================================================================
interface mac_sequencer_if #(
    parameter int N_STAGE = 5,
    parameter int ACC_W   = 12
);
    localparam int N = 2 ** N_STAGE;

    logic               cfg_we;
    logic [N-1:0]       cfg_wdata;
    logic               in_valid;
    logic               in_ready;
    logic [N-1:0]       in_x;
    logic [N-1:0]       w_out;
    logic [N-1:0]       x_out;
    logic [2*N-1:0]     mult_in;
    logic [ACC_W-1:0]   threshold;
    logic [2:0]         leak_shift;
    logic               mem_clr;
    logic               out_valid;
    logic               spike;
    logic [ACC_W-1:0]   membrane;

    modport slave (
        input  cfg_we, cfg_wdata, in_valid, in_x, mult_in, threshold, leak_shift, mem_clr,
        output in_ready, w_out, x_out, out_valid, spike, membrane
    );

    modport master (
        output cfg_we, cfg_wdata, in_valid, in_x, mult_in, threshold, leak_shift, mem_clr,
        input  in_ready, w_out, x_out, out_valid, spike, membrane
    );
endinterface
`default_nettype wire

// File: rtl/mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mac_sequencer
// Description : Serial lane-by-lane MAC controller feeding a leaky
//               integrate-and-fire membrane with saturating accumulate.
// Revision    : 1.0  initial release
// ============================================================================
module mac_sequencer #(
    parameter int N_STAGE = 5,
    parameter int ACC_W   = 12
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mac_sequencer_if.slave    bus
);
    localparam int N = 2 ** N_STAGE;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SUM    = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [N-1:0]         r_w;
    logic [N-1:0]         r_x;
    logic [N_STAGE-1:0]   r_cnt;
    logic [N_STAGE+1:0]   r_psum;
    logic [ACC_W-1:0]     r_mem;
    logic                 r_out_valid;
    logic                 r_spike;

    logic                 w_accept;
    logic [1:0]           w_lane;
    logic [ACC_W:0]       w_sum;
    logic [ACC_W-1:0]     w_m;
    logic [ACC_W-1:0]     w_leaked;
    logic                 w_fire;

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.w_out     = r_w;
    assign bus.x_out     = r_x;
    assign bus.out_valid = r_out_valid;
    assign bus.spike     = r_spike;
    assign bus.membrane  = r_mem;

    assign w_accept = bus.in_valid && (r_state == S_IDLE);
    assign w_lane   = bus.mult_in[{r_cnt, 1'b0} +: 2];

    // One extra carry bit lets the saturation test see the overflow directly.
    assign w_sum    = {1'b0, r_mem} + {{(ACC_W - N_STAGE - 1){1'b0}}, r_psum};
    assign w_m      = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
    assign w_fire   = (w_m >= bus.threshold);
    assign w_leaked = (bus.leak_shift == 3'd0) ? w_m : (w_m - (w_m >> bus.leak_shift));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next_state = S_SUM;
            S_SUM:    if (&r_cnt)   w_next_state = S_UPDATE;
            S_UPDATE: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w         <= '0;
            r_x         <= '0;
            r_cnt       <= '0;
            r_psum      <= '0;
            r_mem       <= '0;
            r_out_valid <= 1'b0;
            r_spike     <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cfg_we) r_w <= bus.cfg_wdata;
                    if (w_accept) begin
                        r_x    <= bus.in_x;
                        r_cnt  <= '0;
                        r_psum <= '0;
                    end
                end
                S_SUM: begin
                    r_psum <= r_psum + {{N_STAGE{1'b0}}, w_lane};
                    r_cnt  <= r_cnt + 1'b1;
                end
                S_UPDATE: begin
                    r_out_valid <= 1'b1;
                    if (w_fire) begin
                        r_spike <= 1'b1;
                        r_mem   <= '0;
                    end else begin
                        r_spike <= 1'b0;
                        r_mem   <= w_leaked;
                    end
                end
                default: ;
            endcase
            // Clear wins over the update; a coincident result reports no spike.
            if (bus.mem_clr) begin
                r_mem <= '0;
                if (r_state == S_UPDATE) r_spike <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_sequencer
// Description : Directed scoreboard bench for mac_sequencer with a behavioural
//               multiplier stage.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mac_sequencer;
    localparam int N_STAGE = 5;
    localparam int ACC_W   = 12;
    localparam int N       = 2 ** N_STAGE;
    localparam logic [N-1:0] ONES = '1;

    typedef struct {
        logic             spk;
        logic [ACC_W-1:0] mem;
        int               due;
    } exp_t;

    logic       clk;
    logic       rst_n;
    int         cyc;
    int         ncmp;
    int         nfail;
    logic [1:0] prod_val;
    exp_t       sb_q[$];
    exp_t       mon_e;

    mac_sequencer_if #(.N_STAGE(N_STAGE), .ACC_W(ACC_W)) bus();

    mac_sequencer #(.N_STAGE(N_STAGE), .ACC_W(ACC_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stage: lane product is prod_val when both bits are set.
    always_comb begin
        bus.mult_in = '0;
        for (int i = 0; i < N; i++)
            bus.mult_in[2*i +: 2] = (bus.w_out[i] & bus.x_out[i]) ? prod_val : 2'b00;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (sb_q.size() == 0) begin
                ncmp++;
                nfail++;
                $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("spike", {31'd0, bus.spike}, {31'd0, mon_e.spk});
                chk("membrane", {20'd0, bus.membrane}, {20'd0, mon_e.mem});
                chk("latency", cyc, mon_e.due);
            end
        end
    end

    task automatic send(input logic [N-1:0] x, input bit push, input bit spk, input int mem);
        int   guard;
        exp_t e;
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            ncmp++;
            nfail++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        bus.in_x     = x;
        bus.in_valid = 1'b1;
        if (push) begin
            e.spk = spk;
            e.mem = mem[ACC_W-1:0];
            e.due = cyc + N + 2;
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb_q.size() != 0 || !bus.in_ready) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            ncmp++;
            nfail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
        end
    endtask

    task automatic load_w(input logic [N-1:0] w);
        bus.cfg_wdata = w;
        bus.cfg_we    = 1'b1;
        @(negedge clk);
        bus.cfg_we    = 1'b0;
    endtask

    task automatic clr_mem();
        bus.mem_clr = 1'b1;
        @(negedge clk);
        bus.mem_clr = 1'b0;
    endtask

    initial begin
        ncmp           = 0;
        nfail          = 0;
        prod_val       = 2'd1;
        rst_n          = 1'b0;
        bus.cfg_we     = 1'b0;
        bus.cfg_wdata  = '0;
        bus.in_valid   = 1'b0;
        bus.in_x       = '0;
        bus.threshold  = 12'd10;
        bus.leak_shift = 3'd0;
        bus.mem_clr    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_spike", {31'd0, bus.spike}, 32'd0);
        chk("rst_membrane", {20'd0, bus.membrane}, 32'd0);
        chk("rst_w_out", bus.w_out, 32'd0);
        chk("rst_x_out", bus.x_out, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Accumulate and fire
        load_w(ONES);
        send(32'h0000000F, 1, 0, 4);
        send(32'h0000000F, 1, 0, 8);
        send(32'h0000000F, 1, 1, 0);
        drain();

        // Leak
        bus.threshold  = 12'd4095;
        bus.leak_shift = 3'd1;
        send(ONES, 1, 0, 16);
        send(ONES, 1, 0, 24);
        send(ONES, 1, 0, 28);
        drain();

        // Asynchronous reset in the middle of SUM
        send(ONES, 0, 0, 0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_spike", {31'd0, bus.spike}, 32'd0);
        chk("midrst_membrane", {20'd0, bus.membrane}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 5) @(negedge clk);
        chk("postrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("postrst_w_out", bus.w_out, 32'd0);

        // Saturation
        bus.leak_shift = 3'd0;
        load_w(ONES);
        for (int i = 0; i < 127; i++)
            send(ONES, 1, 0, 32 * (i + 1));
        send(ONES, 1, 1, 0);
        drain();

        // in_valid held through SUM: single latch, in_ready low
        bus.in_x     = ONES;
        bus.in_valid = 1'b1;
        mon_e.spk    = 1'b0;
        mon_e.mem    = 12'd32;
        mon_e.due    = cyc + N + 2;
        sb_q.push_back(mon_e);
        @(negedge clk);
        bus.in_x = '0;
        for (int i = 0; i < N; i++) begin
            chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("hold_x_out", bus.x_out, ONES);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        drain();

        // Weight write during SUM is ignored
        send(ONES, 1, 0, 64);
        bus.cfg_wdata = '0;
        bus.cfg_we    = 1'b1;
        repeat (3) @(negedge clk);
        bus.cfg_we    = 1'b0;
        drain();
        chk("sum_cfg_ignored", bus.w_out, ONES);

        // Weight write and handshake in the same IDLE cycle
        clr_mem();
        chk("idle_mem_clr", {20'd0, bus.membrane}, 32'd0);
        bus.cfg_wdata = 32'h000000FF;
        bus.cfg_we    = 1'b1;
        send(ONES, 1, 0, 8);
        bus.cfg_we    = 1'b0;
        drain();
        chk("same_cycle_cfg", bus.w_out, 32'h000000FF);

        // mem_clr coinciding with UPDATE
        load_w(ONES);
        clr_mem();
        send(32'h000FFFFF, 1, 0, 20);
        send(ONES, 1, 0, 0);
        repeat (N) @(negedge clk);
        bus.mem_clr = 1'b1;
        @(negedge clk);
        bus.mem_clr = 1'b0;
        drain();

        // Wider lane products, equality threshold, zero threshold
        prod_val = 2'd3;
        send(32'h0000000F, 1, 0, 12);
        drain();
        prod_val      = 2'd2;
        bus.threshold = 12'd20;
        send(32'h0000000F, 1, 1, 0);
        drain();
        prod_val      = 2'd1;
        bus.threshold = 12'd0;
        send(32'h00000000, 1, 1, 0);
        drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
`default_nettype wire
